// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU control unit and the loader port.
// Round-robin grant, latched payload, fixed-latency access, one-cycle ack.
module mem_port_arbiter #(
   parameter int AW   = 5,
   parameter int DW   = 8,
   parameter int WAIT = 1
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_e;

   localparam logic [2:0] WAIT_C = 3'(WAIT);

   state_e        state_q, state_d;
   logic          last_q, last_d;
   logic          gnt_q, gnt_d;
   logic          we_q, we_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          pick_dbg;

   // Ties go to whoever was not served last; last=1 means loader.
   assign pick_dbg = dbg_req & (~cpu_req | ~last_q);

   // State register and latched payload; reset aborts any access.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         cnt_q   <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state: arbitrate in IDLE, count wait cycles, then one ack cycle.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               gnt_d   = pick_dbg;
               we_d    = pick_dbg ? dbg_we : cpu_we;
               addr_d  = pick_dbg ? dbg_addr : cpu_addr;
               wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
               cnt_d   = WAIT_C;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == 3'd0) begin
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ACK: begin
            last_d  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cpu_ack   = (state_q == ACK) & ~gnt_q;
   assign dbg_ack   = (state_q == ACK) & gnt_q;
   assign busy      = (state_q != IDLE);
   assign mem_we    = (state_q == ACCESS) & (cnt_q == WAIT_C) & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;

endmodule
